// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_mem_arbiter_pkg: shared state encoding, requester ids, write-back address helpers
// Revision: 1.0
// ----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2
    } arb_state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int TAG_W     = 28;
    localparam int TAG_SHIFT = 4;

    // Write-back address is the line tag followed by a zero line offset.
    function automatic logic [31:0] wb_addr(input logic [TAG_W-1:0] tag);
        return {tag, {TAG_SHIFT{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_rr_pick2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick2: combinational two-way round-robin select; the requester not served last wins ties
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_pick2
    import cache_mem_arbiter_pkg::*;
(
    input  logic [1:0] pending,
    input  logic       last,
    output logic       grant,
    output logic       any
);

    always_comb begin
        grant = REQ_ICACHE;
        if (pending == 2'b11) begin
            grant = ~last;
        end else if (pending[1]) begin
            grant = REQ_DCACHE;
        end
        any = |pending;
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_mem_arbiter: shares one memory port between I-cache and D-cache, write-back before refill
// Revision: 1.0
// ----------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [1:0]  req_ReadValid,
    input  logic [63:0] req_ReadAddr,
    input  logic [1:0]  req_WriteValid,
    input  logic [55:0] req_WriteTag,
    input  logic [63:0] req_WriteData,
    output logic [1:0]  req_ReadReady,
    output logic [31:0] req_ReadData,
    output logic [1:0]  req_WriteAck,
    output logic        mem_Valid,
    output logic        mem_RW,
    output logic [31:0] mem_Addr,
    output logic [31:0] mem_WriteData,
    input  logic        mem_Ready,
    input  logic [31:0] mem_ReadData,
    output logic        err_Timeout
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state;
    logic             last;
    logic             grant;
    logic [WD_W-1:0]  wdog;

    logic             pick;
    logic             pick_any;
    logic [31:0]      pick_raddr;
    logic [TAG_W-1:0] pick_tag;
    logic [31:0]      pick_wdata;
    logic [31:0]      grant_raddr;
    logic             wd_expire;
    logic             rd_done;

    rr_pick2 u_pick (
        .pending (req_ReadValid | req_WriteValid),
        .last    (last),
        .grant   (pick),
        .any     (pick_any)
    );

    assign pick_raddr  = pick  ? req_ReadAddr[63:32]  : req_ReadAddr[31:0];
    assign pick_tag    = pick  ? req_WriteTag[55:28]  : req_WriteTag[27:0];
    assign pick_wdata  = pick  ? req_WriteData[63:32] : req_WriteData[31:0];
    assign grant_raddr = grant ? req_ReadAddr[63:32]  : req_ReadAddr[31:0];
    assign wd_expire   = (TIMEOUT != 0) && (wdog == WD_LAST);

    // The memory-side output registers double as the latched tag/data for the write-back.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state         <= ST_IDLE;
            last          <= 1'b1;
            grant         <= 1'b0;
            wdog          <= '0;
            mem_Valid     <= 1'b0;
            mem_RW        <= 1'b0;
            mem_Addr      <= '0;
            mem_WriteData <= '0;
            err_Timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant     <= pick;
                        wdog      <= '0;
                        mem_Valid <= 1'b1;
                        if (req_WriteValid[pick]) begin
                            state         <= ST_WB;
                            mem_RW        <= 1'b1;
                            mem_Addr      <= wb_addr(pick_tag);
                            mem_WriteData <= pick_wdata;
                        end else begin
                            state         <= ST_RD;
                            mem_RW        <= 1'b0;
                            mem_Addr      <= pick_raddr;
                            mem_WriteData <= '0;
                        end
                    end
                end
                ST_WB, ST_RD: begin
                    if (mem_Ready && state == ST_WB && req_ReadValid[grant]) begin
                        state         <= ST_RD;
                        wdog          <= '0;
                        mem_RW        <= 1'b0;
                        mem_Addr      <= grant_raddr;
                        mem_WriteData <= '0;
                    end else if (mem_Ready || wd_expire) begin
                        state         <= ST_IDLE;
                        last          <= grant;
                        mem_Valid     <= 1'b0;
                        mem_RW        <= 1'b0;
                        mem_Addr      <= '0;
                        mem_WriteData <= '0;
                        if (!mem_Ready) begin
                            err_Timeout <= 1'b1;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_Valid <= 1'b0;
                end
            endcase
        end
    end

    // A refill strobe is withheld if the requester abandoned its read mid-transaction.
    assign rd_done = (state == ST_RD) && mem_Ready && req_ReadValid[grant];

    always_comb begin
        req_ReadReady = 2'b00;
        req_ReadData  = '0;
        req_WriteAck  = 2'b00;
        if (rd_done) begin
            req_ReadReady[grant] = 1'b1;
            req_ReadData         = mem_ReadData;
        end
        if (state == ST_WB && mem_Ready) begin
            req_WriteAck[grant] = 1'b1;
        end
    end

endmodule
`default_nettype wire
